// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter
//   Shares one external memory port between the hart's instruction-fetch port
//   and its data-memory port. Contention is resolved round-robin, and at most
//   one memory transaction is outstanding at any time.
//
// Optional feature macro: ARB_ATOMIC_LOCK_EN
//   When defined, a data transaction that completes with i_DM_atomic=1 locks
//   the arbiter onto the data side until a data transaction completes with
//   i_DM_atomic=0. When undefined, i_DM_atomic is ignored.
//
// Handshake (both requester sides and the memory side):
//   A requester raises its req with a stable payload and holds both until its
//   ready pulse; ready is a single-cycle pulse and read data is valid only in
//   that cycle (and forced to zero otherwise). The arbiter latches the payload
//   at grant, so a requester that drops req after the grant does not abort the
//   transaction. On the memory side o_MEM_req and payload are held stable until
//   the single-cycle i_MEM_ready completion pulse; i_MEM_ready is ignored when
//   nothing is outstanding.
//
// Ports:
//   i_clk, i_rst           clock (rising edge), asynchronous active-low reset
//   i_IC_DataReq, i_IM_Addr          instruction fetch request / address
//   o_IC_MemReady, o_IM_Instr        fetch completion pulse / fetched word
//   i_DM_req/we/be/addr/wdata/atomic data request and payload
//   o_DM_ready, o_DM_rdata           data completion pulse / read data
//   o_MEM_req/we/be/addr/wdata       registered memory request and payload
//   i_MEM_rdata, i_MEM_ready         memory read data / completion pulse
//   o_dbg_state            FSM state: 0 = IDLE, 1 = GNT_I, 2 = GNT_D
module hart_mem_arbiter #(
  parameter int XLEN             = 32,
  parameter bit LAST_GRANT_RESET = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_IC_DataReq,
  input  logic [XLEN-1:0]   i_IM_Addr,
  output logic              o_IC_MemReady,
  output logic [XLEN-1:0]   o_IM_Instr,
  input  logic              i_DM_req,
  input  logic              i_DM_we,
  input  logic [XLEN/8-1:0] i_DM_be,
  input  logic [XLEN-1:0]   i_DM_addr,
  input  logic [XLEN-1:0]   i_DM_wdata,
  output logic              o_DM_ready,
  output logic [XLEN-1:0]   o_DM_rdata,
  input  logic              i_DM_atomic,
  output logic              o_MEM_req,
  output logic              o_MEM_we,
  output logic [XLEN/8-1:0] o_MEM_be,
  output logic [XLEN-1:0]   o_MEM_addr,
  output logic [XLEN-1:0]   o_MEM_wdata,
  input  logic [XLEN-1:0]   i_MEM_rdata,
  input  logic              i_MEM_ready,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;   // 0 = instruction won last, 1 = data won last
  logic   fetch_req;    // fetch request as seen by arbitration
  logic   grant_i;
  logic   grant_d;

`ifdef ARB_ATOMIC_LOCK_EN
  logic lock;
  // While locked, pending fetches are hidden from arbitration. Every locked
  // completion is a data completion, so last_grant keeps pointing at data and
  // fairness only swings back to instruction once the lock has cleared.
  assign fetch_req = i_IC_DataReq & ~lock;
`else
  logic unused_atomic;
  assign unused_atomic = i_DM_atomic;
  assign fetch_req     = i_IC_DataReq;
`endif

  // Round-robin: on contention, the side that did not win last time wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (fetch_req && i_DM_req) begin
      grant_i = last_grant;
      grant_d = ~last_grant;
    end else begin
      grant_i = fetch_req;
      grant_d = i_DM_req;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      last_grant  <= LAST_GRANT_RESET;
      o_MEM_req   <= 1'b0;
      o_MEM_we    <= 1'b0;
      o_MEM_be    <= '0;
      o_MEM_addr  <= '0;
      o_MEM_wdata <= '0;
`ifdef ARB_ATOMIC_LOCK_EN
      lock        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // i_MEM_ready is deliberately not looked at here.
          if (grant_d) begin
            state       <= GNT_D;
            o_MEM_req   <= 1'b1;
            o_MEM_we    <= i_DM_we;
            o_MEM_be    <= i_DM_be;
            o_MEM_addr  <= i_DM_addr;
            o_MEM_wdata <= i_DM_wdata;
          end else if (grant_i) begin
            state       <= GNT_I;
            o_MEM_req   <= 1'b1;
            o_MEM_we    <= 1'b0;
            o_MEM_be    <= '1;
            o_MEM_addr  <= i_IM_Addr;
            o_MEM_wdata <= '0;
          end
        end
        GNT_I: begin
          if (i_MEM_ready) begin
            state      <= IDLE;
            o_MEM_req  <= 1'b0;
            last_grant <= 1'b0;
          end
        end
        GNT_D: begin
          if (i_MEM_ready) begin
            state      <= IDLE;
            o_MEM_req  <= 1'b0;
            last_grant <= 1'b1;
`ifdef ARB_ATOMIC_LOCK_EN
            lock       <= i_DM_atomic;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          o_MEM_req <= 1'b0;
        end
      endcase
    end
  end

  // Completion is reported in the same cycle as i_MEM_ready, so the ready
  // pulses and read-data muxes are combinational on the registered state.
  assign o_IC_MemReady = (state == GNT_I) & i_MEM_ready;
  assign o_DM_ready    = (state == GNT_D) & i_MEM_ready;
  assign o_IM_Instr    = o_IC_MemReady ? i_MEM_rdata : '0;
  assign o_DM_rdata    = o_DM_ready    ? i_MEM_rdata : '0;
  assign o_dbg_state   = state;

endmodule
